// File: rtl/prog_run_ctrl.sv
// Run controller: launches the selected program into the PC, gates decoded
// branch/halt requests into PC enables, and tracks RUN cycles with a watchdog.
module prog_run_ctrl #(
    parameter int PC_W        = 10,
    parameter int REL_W       = 6,
    parameter int CNT_W       = 16,
    parameter int PROG_BASE_0 = 0,
    parameter int PROG_BASE_1 = 256,
    parameter int PROG_BASE_2 = 512,
    parameter int PROG_BASE_3 = 768,
    parameter int MAX_CYCLES  = 1000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       ProgSel,
    input  logic             HaltReq,
    input  logic             BranchAbsReq,
    input  logic             BranchRelReq,
    input  logic [PC_W-1:0]  AbsTargetIn,
    input  logic [REL_W-1:0] RelTargetIn,
    input  logic             StallReq,
    output logic             PcLoadEn,
    output logic [PC_W-1:0]  PcLoadAddr,
    output logic             PcHold,
    output logic             BranchAbsEn,
    output logic             BranchRelEn,
    output logic [PC_W-1:0]  AbsTarget,
    output logic [REL_W-1:0] RelTarget,
    output logic             Busy,
    output logic             Done,
    output logic             Timeout,
    output logic [CNT_W-1:0] CycleCount
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } runState_t;

    localparam bit               WD_EN   = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

    runState_t        state;
    runState_t        stateNext;
    logic [1:0]       selQ;
    logic [CNT_W-1:0] cycleCount;
    logic             timeoutQ;
    logic             haltAccept;
    logic             wdFire;

    // Halt is only honoured once the current instruction has completed.
    assign haltAccept = (state == RUN) && HaltReq && !StallReq;
    assign wdFire     = WD_EN && (state == RUN) && (cycleCount == WD_LAST);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            selQ       <= '0;
            cycleCount <= '0;
            timeoutQ   <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE, HALTED: begin
                    if (Start) begin
                        selQ     <= ProgSel;
                        timeoutQ <= 1'b0;
                    end
                end
                LAUNCH: cycleCount <= '0;
                RUN: begin
                    if (cycleCount != '1)
                        cycleCount <= cycleCount + 1'b1;
                    if (haltAccept)
                        timeoutQ <= 1'b0;
                    else if (wdFire)
                        timeoutQ <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext   = state;
        PcLoadEn    = 1'b0;
        PcHold      = 1'b1;
        BranchAbsEn = 1'b0;
        BranchRelEn = 1'b0;
        case (state)
            IDLE, HALTED: begin
                if (Start)
                    stateNext = LAUNCH;
            end
            LAUNCH: begin
                PcLoadEn  = 1'b1;
                stateNext = RUN;
            end
            RUN: begin
                PcHold      = StallReq | HaltReq;
                BranchAbsEn = BranchAbsReq & ~StallReq & ~HaltReq;
                BranchRelEn = BranchRelReq & ~BranchAbsReq & ~StallReq & ~HaltReq;
                if (haltAccept || wdFire)
                    stateNext = HALTED;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        case (selQ)
            2'd0:    PcLoadAddr = PC_W'(PROG_BASE_0);
            2'd1:    PcLoadAddr = PC_W'(PROG_BASE_1);
            2'd2:    PcLoadAddr = PC_W'(PROG_BASE_2);
            default: PcLoadAddr = PC_W'(PROG_BASE_3);
        endcase
    end

    assign AbsTarget  = AbsTargetIn;
    assign RelTarget  = RelTargetIn;
    assign Busy       = (state == LAUNCH) || (state == RUN);
    assign Done       = (state == HALTED);
    assign Timeout    = timeoutQ;
    assign CycleCount = cycleCount;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl: launch, branch gating, halt, watchdog,
// restart and asynchronous reset, with hand-computed expectations.
module tb_prog_run_ctrl;

    localparam int PC_W  = 10;
    localparam int REL_W = 6;
    localparam int CNT_W = 16;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [1:0]       ProgSel;
    logic             HaltReq;
    logic             BranchAbsReq;
    logic             BranchRelReq;
    logic [PC_W-1:0]  AbsTargetIn;
    logic [REL_W-1:0] RelTargetIn;
    logic             StallReq;
    logic             PcLoadEn;
    logic [PC_W-1:0]  PcLoadAddr;
    logic             PcHold;
    logic             BranchAbsEn;
    logic             BranchRelEn;
    logic [PC_W-1:0]  AbsTarget;
    logic [REL_W-1:0] RelTarget;
    logic             Busy;
    logic             Done;
    logic             Timeout;
    logic [CNT_W-1:0] CycleCount;

    int unsigned assertCount = 0;
    int unsigned failCount   = 0;
    int unsigned waited;

    prog_run_ctrl #(
        .PC_W       (PC_W),
        .REL_W      (REL_W),
        .CNT_W      (CNT_W),
        .MAX_CYCLES (20)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .ProgSel      (ProgSel),
        .HaltReq      (HaltReq),
        .BranchAbsReq (BranchAbsReq),
        .BranchRelReq (BranchRelReq),
        .AbsTargetIn  (AbsTargetIn),
        .RelTargetIn  (RelTargetIn),
        .StallReq     (StallReq),
        .PcLoadEn     (PcLoadEn),
        .PcLoadAddr   (PcLoadAddr),
        .PcHold       (PcHold),
        .BranchAbsEn  (BranchAbsEn),
        .BranchRelEn  (BranchRelEn),
        .AbsTarget    (AbsTarget),
        .RelTarget    (RelTarget),
        .Busy         (Busy),
        .Done         (Done),
        .Timeout      (Timeout),
        .CycleCount   (CycleCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, ".PcLoadEn"},    32'(PcLoadEn),    32'd0);
        checkVal({tag, ".PcLoadAddr"},  32'(PcLoadAddr),  32'd0);
        checkVal({tag, ".PcHold"},      32'(PcHold),      32'd1);
        checkVal({tag, ".BranchAbsEn"}, 32'(BranchAbsEn), 32'd0);
        checkVal({tag, ".BranchRelEn"}, 32'(BranchRelEn), 32'd0);
        checkVal({tag, ".Busy"},        32'(Busy),        32'd0);
        checkVal({tag, ".Done"},        32'(Done),        32'd0);
        checkVal({tag, ".Timeout"},     32'(Timeout),     32'd0);
        checkVal({tag, ".CycleCount"},  32'(CycleCount),  32'd0);
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; ProgSel = 2'd0; HaltReq = 1'b0;
        BranchAbsReq = 1'b0; BranchRelReq = 1'b0; AbsTargetIn = '0;
        RelTargetIn = '0; StallReq = 1'b0;

        #12;
        checkResetOutputs("rst");
        Reset = 1'b1;

        // Launch program 2
        Start = 1'b1; ProgSel = 2'd2;
        tick();
        Start = 1'b0;
        checkVal("launch.PcLoadEn",   32'(PcLoadEn),   32'd1);
        checkVal("launch.PcLoadAddr", 32'(PcLoadAddr), 32'd512);
        checkVal("launch.Busy",       32'(Busy),       32'd1);
        checkVal("launch.PcHold",     32'(PcHold),     32'd1);
        tick();
        checkVal("run.PcLoadEn",   32'(PcLoadEn),   32'd0);
        checkVal("run.PcHold",     32'(PcHold),     32'd0);
        checkVal("run.CycleCount", 32'(CycleCount), 32'd0);

        // Branch gating within RUN cycle 1
        BranchAbsReq = 1'b1; BranchRelReq = 1'b1; AbsTargetIn = 10'd10;
        #1;
        checkVal("absWins.BranchAbsEn", 32'(BranchAbsEn), 32'd1);
        checkVal("absWins.BranchRelEn", 32'(BranchRelEn), 32'd0);
        checkVal("absWins.AbsTarget",   32'(AbsTarget),   32'd10);
        StallReq = 1'b1;
        #1;
        checkVal("stall.BranchAbsEn", 32'(BranchAbsEn), 32'd0);
        checkVal("stall.BranchRelEn", 32'(BranchRelEn), 32'd0);
        checkVal("stall.PcHold",      32'(PcHold),      32'd1);
        StallReq = 1'b0; BranchAbsReq = 1'b0; RelTargetIn = 6'd5;
        #1;
        checkVal("rel.BranchRelEn", 32'(BranchRelEn), 32'd1);
        checkVal("rel.RelTarget",   32'(RelTarget),   32'd5);
        tick();
        BranchRelReq = 1'b0;

        // RUN cycle 2: halt during stall is ignored
        HaltReq = 1'b1; StallReq = 1'b1;
        #1;
        checkVal("haltStall.PcHold", 32'(PcHold), 32'd1);
        tick();
        HaltReq = 1'b0; StallReq = 1'b0;
        checkVal("haltStall.Busy", 32'(Busy), 32'd1);
        checkVal("haltStall.Done", 32'(Done), 32'd0);

        // Cycles 3..5, then halt in cycle 6 (also blocks an absolute branch)
        repeat (3) tick();
        HaltReq = 1'b1; BranchAbsReq = 1'b1;
        #1;
        checkVal("halt.BranchAbsEn", 32'(BranchAbsEn), 32'd0);
        checkVal("halt.PcHoldRun",   32'(PcHold),      32'd1);
        tick();
        HaltReq = 1'b0; BranchAbsReq = 1'b0;
        checkVal("halt.Done",       32'(Done),       32'd1);
        checkVal("halt.Busy",       32'(Busy),       32'd0);
        checkVal("halt.Timeout",    32'(Timeout),    32'd0);
        checkVal("halt.CycleCount", 32'(CycleCount), 32'd6);
        checkVal("halt.PcHold",     32'(PcHold),     32'd1);
        tick();
        checkVal("halted.CycleHold", 32'(CycleCount), 32'd6);

        // Restart from HALTED with program 1
        Start = 1'b1; ProgSel = 2'd1;
        tick();
        Start = 1'b0;
        checkVal("restart.PcLoadAddr", 32'(PcLoadAddr), 32'd256);
        checkVal("restart.PcLoadEn",   32'(PcLoadEn),   32'd1);
        checkVal("restart.Done",       32'(Done),       32'd0);
        checkVal("restart.Timeout",    32'(Timeout),    32'd0);
        tick();
        checkVal("restart.CycleCount", 32'(CycleCount), 32'd0);

        // Start in RUN has no effect
        Start = 1'b1; ProgSel = 2'd3;
        tick();
        Start = 1'b0;
        checkVal("startInRun.Busy",       32'(Busy),       32'd1);
        checkVal("startInRun.PcLoadEn",   32'(PcLoadEn),   32'd0);
        checkVal("startInRun.PcLoadAddr", 32'(PcLoadAddr), 32'd256);
        checkVal("startInRun.CycleCount", 32'(CycleCount), 32'd1);

        // Watchdog: 20 RUN cycles total, 19 remaining
        waited = 0;
        while (!Done && waited < 40) begin
            tick();
            waited++;
        end
        checkVal("wd.waitCycles", 32'(waited),     32'd19);
        checkVal("wd.Done",       32'(Done),       32'd1);
        checkVal("wd.Timeout",    32'(Timeout),    32'd1);
        checkVal("wd.CycleCount", 32'(CycleCount), 32'd20);

        // Rerun, halt in the 20th cycle beats the watchdog
        Start = 1'b1; ProgSel = 2'd0;
        tick();
        Start = 1'b0;
        checkVal("rerun.Timeout", 32'(Timeout), 32'd0);
        tick();
        repeat (19) tick();
        checkVal("rerun.Busy19", 32'(Busy), 32'd1);
        HaltReq = 1'b1;
        tick();
        HaltReq = 1'b0;
        checkVal("haltWd.Done",       32'(Done),       32'd1);
        checkVal("haltWd.Timeout",    32'(Timeout),    32'd0);
        checkVal("haltWd.CycleCount", 32'(CycleCount), 32'd20);

        // Asynchronous reset mid-run with program 3 latched
        Start = 1'b1; ProgSel = 2'd3;
        tick();
        Start = 1'b0;
        checkVal("p3.PcLoadAddr", 32'(PcLoadAddr), 32'd768);
        repeat (3) tick();
        #2;
        Reset = 1'b0;
        #1;
        checkResetOutputs("asyncRst");
        #3;
        Reset = 1'b1;
        Start = 1'b1; ProgSel = 2'd2;
        tick();
        Start = 1'b0;
        checkVal("postRst.PcLoadEn",   32'(PcLoadEn),   32'd1);
        checkVal("postRst.PcLoadAddr", 32'(PcLoadAddr), 32'd512);
        tick();
        checkVal("postRst.Busy",   32'(Busy),   32'd1);
        checkVal("postRst.PcHold", 32'(PcHold), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
